// File: rtl/shuffle_engine_if.sv
// Link between the shuffle controller and the random shuffler: seed load,
// swap-index limit going out, bounded random index coming back.
interface shuffle_engine_if;
  logic        shuffle_init;
  logic [31:0] seed_o;
  logic [3:0]  limit;
  logic [3:0]  prn4;

  modport master (output shuffle_init, output seed_o, output limit, input prn4);
  modport slave  (input shuffle_init, input seed_o, input limit, output prn4);
endinterface

// File: rtl/shuffle_engine.sv
// Fisher-Yates shuffle controller: seeds the shuffler, then walks limit 9..1
// swapping deck[limit] with deck[prn4] to build a permutation of 0..9.
module shuffle_engine (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [31:0]       seed,
  shuffle_engine_if.master  link,
  output logic              busy,
  output logic              done,
  output logic [39:0]       deck,
  input  logic [3:0]        rd_idx,
  output logic [3:0]        rd_data
);

  localparam logic [39:0] IDENTITY = 40'h98765_43210;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    SWAP,
    DONE
  } state_t;

  state_t           state_q, state_nxt;
  logic [3:0]       limit_q, limit_nxt;
  logic             init_q, init_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [31:0]      seed_q, seed_nxt;
  logic [9:0][3:0]  deck_q, deck_nxt;
  logic [3:0]       j;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      limit_q <= 4'd0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seed_q  <= 32'd0;
      deck_q  <= IDENTITY;
    end else begin
      state_q <= state_nxt;
      limit_q <= limit_nxt;
      init_q  <= init_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      seed_q  <= seed_nxt;
      deck_q  <= deck_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    limit_nxt = limit_q;
    init_nxt  = 1'b0;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    seed_nxt  = seed_q;
    deck_nxt  = deck_q;
    // Out-of-range indices collapse onto limit, which turns the swap into a no-op.
    j = (link.prn4 <= limit_q) ? link.prn4 : limit_q;

    case (state_q)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = SEED;
          busy_nxt  = 1'b1;
          init_nxt  = 1'b1;
          limit_nxt = 4'd9;
          deck_nxt  = IDENTITY;
          // An all-zero xorshift state never leaves zero.
          seed_nxt  = (seed == 32'd0) ? 32'h0000_0001 : seed;
        end
      end
      SEED: begin
        state_nxt = SWAP;
        limit_nxt = 4'd9;
      end
      SWAP: begin
        deck_nxt[limit_q] = deck_q[j];
        deck_nxt[j]       = deck_q[limit_q];
        if (limit_q == 4'd1) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          limit_nxt = limit_q - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        limit_nxt = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_data = 4'hF;
    if (rd_idx <= 4'd9) begin
      rd_data = deck_q[rd_idx];
    end
  end

  assign link.shuffle_init = init_q;
  assign link.seed_o       = seed_q;
  assign link.limit        = limit_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign deck              = deck_q;

endmodule

// File: tb/tb_shuffle_engine.sv
// Bench for shuffle_engine: behavioural xorshift32 shuffler on the link,
// golden Fisher-Yates model feeding a scoreboard of expected final decks.
module tb_shuffle_engine;

  localparam logic [39:0] IDENTITY = 40'h98765_43210;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [39:0] deck;
  logic [3:0]  rd_idx;
  logic [3:0]  rd_data;

  shuffle_engine_if link ();

  shuffle_engine dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .seed    (seed),
    .link    (link),
    .busy    (busy),
    .done    (done),
    .deck    (deck),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_count = 0;
  int          mode = 0;
  logic [3:0]  forced = 4'd0;
  logic [31:0] sh_state;
  logic [3:0]  prn_drv;
  logic [39:0] exp_q[$];

  function automatic logic [31:0] xs(logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [39:0] golden(logic [31:0] s_in);
    logic [9:0][3:0] d;
    logic [31:0]     s;
    logic [31:0]     m;
    logic [3:0]      t;
    int              jj;
    d = IDENTITY;
    s = s_in;
    for (int lim = 9; lim >= 1; lim--) begin
      m = 32'(lim) + 32'd1;
      jj = int'(s % m);
      t = d[lim];
      d[lim] = d[jj];
      d[jj] = t;
      s = xs(s);
    end
    return d;
  endfunction

  function automatic bit is_perm(logic [39:0] d);
    logic [15:0] seen;
    seen = 16'd0;
    for (int i = 0; i < 10; i++) seen[d[4*i +: 4]] = 1'b1;
    return (seen == 16'h03FF);
  endfunction

  // Shuffler stand-in: loads the seed on shuffle_init, otherwise steps every edge.
  always @(posedge clk) begin
    if (link.shuffle_init) sh_state <= link.seed_o;
    else sh_state <= xs(sh_state);
  end

  always_comb begin
    logic [31:0] m;
    m = {28'd0, link.limit} + 32'd1;
    prn_drv = forced;
    case (mode)
      1: prn_drv = link.limit;
      2: prn_drv = 4'(sh_state % m);
      default: prn_drv = forced;
    endcase
  end

  assign link.prn4 = prn_drv;

  task automatic check_output(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check_output("busy_done_excl", {39'd0, busy & done}, 40'd0);
      if (mode == 2 && busy && !link.shuffle_init)
        check_output("prn4_range", {39'd0, link.prn4 <= link.limit}, 40'd1);
      if (done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("[TB] FAIL unexpected_done: got done with empty scoreboard, want none");
        end else begin
          check_output("final_deck", deck, exp_q.pop_front());
          check_output("permutation", {39'd0, is_perm(deck)}, 40'd1);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] s, input bit timing, input bit restart,
                                input logic [39:0] exp);
    int          base;
    int          lat;
    int          k;
    logic [31:0] eff;
    eff = (s == 32'd0) ? 32'd1 : s;
    base = done_count;
    @(negedge clk);
    start = 1'b1;
    seed = s;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    seed = $urandom;
    check_output("seed_o", {8'd0, link.seed_o}, {8'd0, eff});
    if (timing) begin
      check_output("init_e0", {39'd0, link.shuffle_init}, 40'd1);
      check_output("limit_e0", {36'd0, link.limit}, 40'd9);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      k = lat + 1;
      if (restart && k == 5) start = 1'b1;
      if (restart && k == 6) start = 1'b0;
      if (timing && !done) begin
        check_output("init_low", {39'd0, link.shuffle_init}, 40'd0);
        if (k >= 2 && k <= 10)
          check_output("limit_seq", {36'd0, link.limit}, 40'(11 - k));
      end
    end
    check_output("latency", 40'(lat), 40'd10);
    if (!done) exp_q.delete();
    @(negedge clk);
    check_output("done_pulse", {39'd0, done}, 40'd0);
    repeat (2) @(negedge clk);
    check_output("done_count", 40'(done_count - base), 40'd1);
  endtask

  task automatic apply_abort(input logic [31:0] s);
    int base;
    base = done_count;
    @(negedge clk);
    start = 1'b1;
    seed = s;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_output("abort_busy", {39'd0, busy}, 40'd0);
    check_output("abort_deck", deck, IDENTITY);
    check_output("abort_limit", {36'd0, link.limit}, 40'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    check_output("abort_no_done", 40'(done_count - base), 40'd0);
  endtask

  initial begin
    logic [31:0] s;
    logic [39:0] e;
    rstn = 1'b0;
    start = 1'b0;
    seed = 32'd0;
    rd_idx = 4'd3;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_output("reset_deck", deck, IDENTITY);
    check_output("reset_busy", {39'd0, busy}, 40'd0);
    check_output("reset_done", {39'd0, done}, 40'd0);
    check_output("reset_init", {39'd0, link.shuffle_init}, 40'd0);
    check_output("reset_limit", {36'd0, link.limit}, 40'd0);
    check_output("reset_seed_o", {8'd0, link.seed_o}, 40'd0);
    check_output("reset_rd3", {36'd0, rd_data}, 40'd3);

    $display("[TB] forced prn4 = 0");
    mode = 0;
    forced = 4'd0;
    apply_stimulus(32'hA5A5_0001, 1'b1, 1'b0, 40'h09876_54321);

    $display("[TB] clamping");
    mode = 1;
    apply_stimulus(32'h0000_0042, 1'b0, 1'b0, IDENTITY);
    mode = 0;
    forced = 4'hF;
    apply_stimulus(32'h0000_0043, 1'b0, 1'b0, IDENTITY);

    $display("[TB] closed loop");
    mode = 2;
    e = golden(32'h1234_5678);
    apply_stimulus(32'h1234_5678, 1'b1, 1'b0, e);
    for (int i = 0; i < 10; i++) begin
      rd_idx = 4'(i);
      #1;
      check_output("rd_port", {36'd0, rd_data}, {36'd0, e[4*i +: 4]});
    end
    for (int n = 0; n < 200; n++) begin
      s = $urandom;
      apply_stimulus(s, 1'b0, 1'b0, golden((s == 32'd0) ? 32'd1 : s));
    end

    $display("[TB] zero seed with ignored start");
    apply_stimulus(32'd0, 1'b1, 1'b1, golden(32'd1));

    $display("[TB] abort");
    apply_abort(32'hCAFE_F00D);
    apply_stimulus(32'hDEAD_BEEF, 1'b1, 1'b0, golden(32'hDEAD_BEEF));

    rd_idx = 4'd12;
    #1;
    check_output("rd_oob", {36'd0, rd_data}, 40'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
